apb_cmd_sequencer: RTL and testbench
====================================

APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Parameters
REQ-001 SHALL provide these parameters, one per line as name, default, meaning:
- DATA_W, 32, APB data width.
- ADDR_W, 32, APB address width.
- DEPTH, 8, command FIFO entries; power of 2, >= 2.
- POLL_MAX, 16, maximum reads per POLL command; >= 1.

Interface
REQ-002 SHALL use clock CLK, rising-edge.
REQ-003 SHALL use reset nRST: asynchronous, active-low, 1 bit.
REQ-004 SHALL provide these ports, one per line as name, direction, width, meaning:
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, FIFO not full.
- cmd_op, in, 2, 00 WRITE / 01 READ / 10 POLL / 11 reserved.
- cmd_addr, in, ADDR_W, target address.
- cmd_data, in, DATA_W, write data (WRITE) or bit mask (POLL); ignored for READ.
- rsp_valid, out, 1, response held.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, DATA_W, last PRDATA sampled.
- rsp_err, out, 1, PSLVERR seen, or POLL timeout.
- PSEL, out, 1, APB select.
- PENABLE, out, 1, APB enable.
- PWRITE, out, 1, APB direction.
- PADDR, out, ADDR_W, APB address.
- PWDATA, out, DATA_W, APB write data.
- PRDATA, in, DATA_W, APB read data.
- PREADY, in, 1, APB ready.
- PSLVERR, in, 1, APB slave error.
- busy, out, 1, FIFO non-empty or FSM not IDLE.

Function
REQ-005 SHALL push {op, addr, data} into the FIFO when cmd_valid && cmd_ready; cmd_ready = (count != DEPTH).
REQ-006 SHALL keep a registered occupancy count, 0..DEPTH; a push and pop in the same cycle leaves count unchanged.
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-008 IDLE: if the FIFO is non-empty, pop the head into a command register and go to SETUP the next cycle; otherwise stay in IDLE.
REQ-009 Reserved op 11 SHALL be popped and discarded with no APB transfer and no response; the FSM stays in IDLE.
REQ-010 SETUP: PSEL=1, PENABLE=0, with PADDR, PWRITE (1 for WRITE only) and PWDATA (cmd_data for WRITE, else 0) driven from the command register; go to ACCESS unconditionally.
REQ-011 ACCESS: PSEL=1, PENABLE=1, address, control and data held stable; remain in ACCESS while PREADY=0.
REQ-012 ACCESS with PREADY=1, WRITE: if PSLVERR=0, go to IDLE with no response; if PSLVERR=1, load rsp_data=0, rsp_err=1 and go to RESP.
REQ-013 ACCESS with PREADY=1, READ: load rsp_data=PRDATA, rsp_err=PSLVERR and go to RESP.
REQ-014 ACCESS with PREADY=1, POLL: increment the poll counter.
- If (PRDATA & mask) != 0, or PSLVERR=1, or the counter reaches POLL_MAX: load the response and go to RESP.
- Otherwise go back to SETUP; each poll is a complete two-phase transfer.
REQ-015 POLL rsp_err SHALL be 1 on PSLVERR or on timeout (POLL_MAX reads with no mask hit); on a mask hit at read POLL_MAX, rsp_err=0.
REQ-016 The poll counter SHALL clear on every pop.
REQ-017 RESP: rsp_valid=1 with rsp_data and rsp_err held stable; on rsp_ready=1, go to IDLE. No new APB transfer starts while in RESP.
REQ-018 Outside SETUP and ACCESS, SHALL drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-019 Minimum latency from the cmd_valid push into an empty, idle block SHALL be:
- PSEL high 2 cycles later;
- for READ with PREADY=1 held, rsp_valid high 4 cycles after the push.
REQ-020 A simultaneous push in the same cycle IDLE pops the last entry SHALL be accepted and executed as the next command.
REQ-021 Commands SHALL execute strictly in FIFO order, one APB transfer in flight at a time.

Reset
REQ-022 While nRST=0, SHALL force:
- FSM=IDLE, FIFO count, pointers and poll counter = 0;
- all APB outputs, rsp_valid, rsp_data and rsp_err = 0;
- cmd_ready=1 and busy=0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer and discard all queued commands; no response is issued after release.

Verification
REQ-024 Scenario WRITE: push WRITE addr 0x10 data 0xDEADBEEF, PREADY=1 -> one SETUP cycle then one ACCESS cycle with PWRITE=1, PWDATA=0xDEADBEEF; no rsp_valid; busy returns to 0.
REQ-025 Scenario READ with wait states: push READ addr 0x14, PREADY low for 3 ACCESS cycles, PRDATA=0x5A -> PENABLE high for 4 cycles, address stable; rsp_data=0x5A, rsp_err=0.
REQ-026 Scenario POLL success: push POLL mask 0x1, PRDATA=0 for 2 reads then 0x1 -> exactly 3 SETUP/ACCESS pairs; rsp_data=0x1, rsp_err=0.
REQ-027 Scenario POLL timeout: POLL_MAX=16, mask 0x1, PRDATA=0 always -> exactly 16 reads; rsp_err=1, rsp_data=0.
REQ-028 Scenario backpressure: push DEPTH+1 commands with rsp_ready=0 -> cmd_ready=0 after DEPTH accepted pushes; the FSM stalls in RESP on the first READ; draining rsp_ready restores in-order execution.
REQ-029 Scenario reset: nRST pulsed low during ACCESS with 3 queued commands -> all outputs 0 immediately, no APB activity after release, busy=0.

Source files
------------

// File: rtl/apb_cmd_sequencer.sv
// APB command sequencer: buffers WRITE/READ/POLL commands in a FIFO and replays them
// as two-phase APB transfers, one at a time, with read/poll results on a held response port.
module apb_cmd_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 8,
    parameter int POLL_MAX = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic              busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    logic [1:0]        fifoOp_q   [DEPTH];
    logic [ADDR_W-1:0] fifoAddr_q [DEPTH];
    logic [DATA_W-1:0] fifoData_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    logic [1:0]        headOp;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;

    state_e            state_q;
    logic [1:0]        cmdOp_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [DATA_W-1:0] cmdData_q;
    logic [POLL_W-1:0] pollCnt_q, pollNext;
    logic              pollHit;

    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rspValid_q, rspErr_q;
    logic [DATA_W-1:0] rspData_q;

    assign cmd_ready = (count_q != CNT_W'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign busy      = (count_q != '0) || (state_q != IDLE);

    assign headOp   = fifoOp_q[rdPtr_q];
    assign headAddr = fifoAddr_q[rdPtr_q];
    assign headData = fifoData_q[rdPtr_q];

    assign pollNext = pollCnt_q + POLL_W'(1);
    assign pollHit  = (PRDATA & cmdData_q) != '0;

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
    assign rsp_err   = rspErr_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            fifoOp_q[wrPtr_q]   <= cmd_op;
            fifoAddr_q[wrPtr_q] <= cmd_addr;
            fifoData_q[wrPtr_q] <= cmd_data;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // All APB and response outputs are registered alongside the state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cmdOp_q    <= OP_WRITE;
            cmdAddr_q  <= '0;
            cmdData_q  <= '0;
            pollCnt_q  <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        pollCnt_q <= '0;
                        if (headOp != OP_RSVD) begin
                            cmdOp_q   <= headOp;
                            cmdAddr_q <= headAddr;
                            cmdData_q <= headData;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            pwrite_q  <= (headOp == OP_WRITE);
                            paddr_q   <= headAddr;
                            pwdata_q  <= (headOp == OP_WRITE) ? headData : '0;
                            state_q   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                        case (cmdOp_q)
                            OP_WRITE: begin
                                if (PSLVERR) begin
                                    rspValid_q <= 1'b1;
                                    rspData_q  <= '0;
                                    rspErr_q   <= 1'b1;
                                    state_q    <= RESP;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                            OP_READ: begin
                                rspValid_q <= 1'b1;
                                rspData_q  <= PRDATA;
                                rspErr_q   <= PSLVERR;
                                state_q    <= RESP;
                            end
                            OP_POLL: begin
                                pollCnt_q <= pollNext;
                                if (pollHit || PSLVERR || (pollNext == POLL_W'(POLL_MAX))) begin
                                    rspValid_q <= 1'b1;
                                    rspData_q  <= PRDATA;
                                    // Without a slave error, finishing with no mask hit means timeout.
                                    rspErr_q   <= PSLVERR || !pollHit;
                                    state_q    <= RESP;
                                end else begin
                                    psel_q  <= 1'b1;
                                    paddr_q <= cmdAddr_q;
                                    state_q <= SETUP;
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer: a per-cycle vector table for single transfers,
// plus hand-written sequences for latency, polling, backpressure and reset abort.
module tb_apb_cmd_sequencer;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 8;
    localparam int POLL_MAX = 16;

    logic              CLK, nRST;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              busy;

    apb_cmd_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .POLL_MAX(POLL_MAX)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] cmdValid, op, addr, data, pready, prdata, pslverr, rspReady;
        logic [31:0] ePsel, ePen, ePwrite, ePaddr, ePwdata, eRspValid, eRspData, eRspErr, eBusy, eCmdReady;
    } vec_t;

    vec_t        vecs[$];
    int          errors;
    int          checks;
    logic [31:0] addrQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic addVec(input string name,
                          input logic [31:0] cv, op, addr, data, pready, prdata, pslverr, rr,
                          input logic [31:0] psel, pen, pwr, paddr, pwdata, rv, rdata, rerr, bsy, crdy);
        vec_t v;
        v.name = name;
        v.cmdValid = cv; v.op = op; v.addr = addr; v.data = data;
        v.pready = pready; v.prdata = prdata; v.pslverr = pslverr; v.rspReady = rr;
        v.ePsel = psel; v.ePen = pen; v.ePwrite = pwr; v.ePaddr = paddr; v.ePwdata = pwdata;
        v.eRspValid = rv; v.eRspData = rdata; v.eRspErr = rerr; v.eBusy = bsy; v.eCmdReady = crdy;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_valid = v.cmdValid[0];
        cmd_op    = v.op[1:0];
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        PREADY    = v.pready[0];
        PRDATA    = v.prdata;
        PSLVERR   = v.pslverr[0];
        rsp_ready = v.rspReady[0];
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".psel"},    32'(PSEL),      v.ePsel);
        checkOutput({v.name, ".penable"}, 32'(PENABLE),   v.ePen);
        checkOutput({v.name, ".pwrite"},  32'(PWRITE),    v.ePwrite);
        checkOutput({v.name, ".paddr"},   PADDR,          v.ePaddr);
        checkOutput({v.name, ".pwdata"},  PWDATA,         v.ePwdata);
        checkOutput({v.name, ".rsp_valid"}, 32'(rsp_valid), v.eRspValid);
        if (v.eRspValid[0]) begin
            checkOutput({v.name, ".rsp_data"}, rsp_data,     v.eRspData);
            checkOutput({v.name, ".rsp_err"},  32'(rsp_err), v.eRspErr);
        end
        checkOutput({v.name, ".busy"},      32'(busy),      v.eBusy);
        checkOutput({v.name, ".cmd_ready"}, 32'(cmd_ready), v.eCmdReady);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".psel"},      32'(PSEL),      0);
        checkOutput({name, ".penable"},   32'(PENABLE),   0);
        checkOutput({name, ".pwrite"},    32'(PWRITE),    0);
        checkOutput({name, ".paddr"},     PADDR,          0);
        checkOutput({name, ".pwdata"},    PWDATA,         0);
        checkOutput({name, ".rsp_valid"}, 32'(rsp_valid), 0);
        checkOutput({name, ".rsp_data"},  rsp_data,       0);
        checkOutput({name, ".rsp_err"},   32'(rsp_err),   0);
        checkOutput({name, ".cmd_ready"}, 32'(cmd_ready), 1);
        checkOutput({name, ".busy"},      32'(busy),      0);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(busy), 0);
    endtask

    task automatic pushCmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    // PRDATA for each poll read is set while that read is in its ACCESS cycle.
    task automatic runPoll(input string name, input int hitAt, input int expReads,
                           input logic [31:0] expData, input logic expErr);
        int   setups = 0;
        int   reads  = 0;
        int   bad    = 0;
        logic done   = 1'b0;
        rsp_ready = 1'b0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        pushCmd(2'b10, 32'h40, 32'h1);
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (PSEL && PENABLE) begin
                reads++;
                PRDATA = (hitAt != 0 && reads >= hitAt) ? 32'h1 : 32'h0;
            end else if (PSEL) begin
                setups++;
            end
            if (PSEL && (PADDR != 32'h40 || PWRITE || PWDATA != 0)) bad++;
            if (rsp_valid) done = 1'b1;
        end
        checkOutput({name, ".finished"}, 32'(done), 1);
        checkOutput({name, ".setups"},   setups, expReads);
        checkOutput({name, ".reads"},    reads,  expReads);
        checkOutput({name, ".apb_bus"},  bad,    0);
        checkOutput({name, ".rsp_data"}, rsp_data, expData);
        checkOutput({name, ".rsp_err"},  32'(rsp_err), 32'(expErr));
        tick();
        checkOutput({name, ".rsp_hold"}, 32'(rsp_valid), 1);
        checkOutput({name, ".data_hold"}, rsp_data, expData);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        PRDATA    = '0;
        checkOutput({name, ".rsp_drop"}, 32'(rsp_valid), 0);
        checkOutput({name, ".idle"},     32'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        int   stall;
        int   activity;
        logic readyBefore;

        errors = 0;
        checks = 0;
        nRST = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = '0;

        repeat (3) @(posedge CLK);
        #1;
        checkAllZero("reset");
        @(negedge CLK);
        nRST = 1'b1;

        //      name         cv op addr   data          prdy prdata pserr rr  psel pen pwr paddr  pwdata        rv rdata  rerr busy crdy
        addVec("w_push",     1, 0, 'h10, 'hDEADBEEF,   1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   1, 1);
        addVec("w_setup",    0, 0, 0,    0,            1, 0,    0, 0,   1, 0, 1, 'h10, 'hDEADBEEF,   0, 0,    0,   1, 1);
        addVec("w_access",   0, 0, 0,    0,            1, 0,    0, 0,   1, 1, 1, 'h10, 'hDEADBEEF,   0, 0,    0,   1, 1);
        addVec("w_done",     0, 0, 0,    0,            1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   0, 1);
        addVec("r_push",     1, 1, 'h14, 'h1234,       0, 'h5A, 0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   1, 1);
        addVec("r_setup",    0, 0, 0,    0,            0, 'h5A, 0, 0,   1, 0, 0, 'h14, 0,            0, 0,    0,   1, 1);
        addVec("r_acc1",     0, 0, 0,    0,            0, 'h5A, 0, 0,   1, 1, 0, 'h14, 0,            0, 0,    0,   1, 1);
        addVec("r_acc2",     0, 0, 0,    0,            0, 'h5A, 0, 0,   1, 1, 0, 'h14, 0,            0, 0,    0,   1, 1);
        addVec("r_acc3",     0, 0, 0,    0,            0, 'h5A, 0, 0,   1, 1, 0, 'h14, 0,            0, 0,    0,   1, 1);
        addVec("r_acc4",     0, 0, 0,    0,            0, 'h5A, 0, 0,   1, 1, 0, 'h14, 0,            0, 0,    0,   1, 1);
        addVec("r_resp",     0, 0, 0,    0,            1, 'h5A, 0, 0,   0, 0, 0, 0,    0,            1, 'h5A, 0,   1, 1);
        addVec("r_hold",     0, 0, 0,    0,            1, 0,    0, 0,   0, 0, 0, 0,    0,            1, 'h5A, 0,   1, 1);
        addVec("r_ack",      0, 0, 0,    0,            1, 0,    0, 1,   0, 0, 0, 0,    0,            0, 0,    0,   0, 1);
        addVec("e_push",     1, 1, 'h20, 0,            1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   1, 1);
        addVec("e_setup",    0, 0, 0,    0,            1, 'hAB, 1, 0,   1, 0, 0, 'h20, 0,            0, 0,    0,   1, 1);
        addVec("e_access",   0, 0, 0,    0,            1, 'hAB, 1, 0,   1, 1, 0, 'h20, 0,            0, 0,    0,   1, 1);
        addVec("e_resp",     0, 0, 0,    0,            1, 'hAB, 1, 0,   0, 0, 0, 0,    0,            1, 'hAB, 1,   1, 1);
        addVec("e_ack",      0, 0, 0,    0,            1, 0,    0, 1,   0, 0, 0, 0,    0,            0, 0,    0,   0, 1);
        addVec("we_push",    1, 0, 'h24, 'hCAFE,       1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   1, 1);
        addVec("we_setup",   0, 0, 0,    0,            1, 'h99, 1, 0,   1, 0, 1, 'h24, 'hCAFE,       0, 0,    0,   1, 1);
        addVec("we_access",  0, 0, 0,    0,            1, 'h99, 1, 0,   1, 1, 1, 'h24, 'hCAFE,       0, 0,    0,   1, 1);
        addVec("we_resp",    0, 0, 0,    0,            1, 'h99, 1, 0,   0, 0, 0, 0,    0,            1, 0,    1,   1, 1);
        addVec("we_ack",     0, 0, 0,    0,            1, 0,    0, 1,   0, 0, 0, 0,    0,            0, 0,    0,   0, 1);
        addVec("x_push",     1, 3, 'h30, 5,            1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   1, 1);
        addVec("x_pop",      0, 0, 0,    0,            1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   0, 1);
        addVec("x_idle",     0, 0, 0,    0,            1, 0,    0, 0,   0, 0, 0, 0,    0,            0, 0,    0,   0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkVector(vecs[i]);
        end

        // Minimum latency, plus a push landing in the same cycle IDLE pops the last entry.
        rsp_ready = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h77;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 32'h50; cmd_data = '0;
        tick();
        cmd_addr = 32'h54;
        tick();
        cmd_valid = 1'b0;
        checkOutput("lat.psel",  32'(PSEL), 1);
        checkOutput("lat.paddr", PADDR, 32'h50);
        tick();
        checkOutput("lat.penable",   32'(PENABLE), 1);
        checkOutput("lat.rsp_early", 32'(rsp_valid), 0);
        tick();
        checkOutput("lat.rsp_valid", 32'(rsp_valid), 1);
        checkOutput("lat.rsp_data",  rsp_data, 32'h77);
        checkOutput("lat.rsp_err",   32'(rsp_err), 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(PSEL && !PENABLE) && n < 20);
        checkOutput("lat.second_addr", PADDR, 32'h54);
        waitIdle("lat.idle");

        runPoll("poll_ok",      3,  3,        32'h1, 1'b0);
        runPoll("poll_timeout", 0,  POLL_MAX, 32'h0, 1'b1);
        runPoll("poll_lasthit", 16, POLL_MAX, 32'h1, 1'b0);

        // Backpressure: first READ parks in RESP, then the FIFO is filled.
        rsp_ready = 1'b0; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h11;
        pushCmd(2'b01, 32'h100, 32'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("bp.first_resp", 32'(rsp_valid), 1);
        for (int i = 1; i <= DEPTH; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = (i % 2 == 1) ? 2'b00 : 2'b01;
            cmd_addr  = 32'h200 + 32'(4 * (i - 1));
            cmd_data  = 32'(i);
            tick();
        end
        checkOutput("bp.full", 32'(cmd_ready), 0);
        cmd_op = 2'b01; cmd_addr = 32'h200 + 32'(4 * DEPTH); cmd_data = '0;
        stall = 0;
        repeat (3) begin
            tick();
            if (PSEL || !rsp_valid || cmd_ready || !busy) stall++;
        end
        checkOutput("bp.stalled", stall, 0);
        rsp_ready = 1'b1;
        readyBefore = cmd_ready;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (cmd_valid && readyBefore) cmd_valid = 1'b0;
            if (PSEL && !PENABLE) addrQ.push_back(PADDR);
            readyBefore = cmd_ready;
            if (!cmd_valid && !busy) break;
        end
        checkOutput("bp.order_count", addrQ.size(), DEPTH + 1);
        for (int k = 0; k < addrQ.size(); k++) begin
            checkOutput($sformatf("bp.order[%0d]", k), addrQ[k], 32'h200 + 32'(4 * k));
        end
        cmd_valid = 1'b0;
        waitIdle("bp.idle");

        // Reset during ACCESS with three commands still queued.
        rsp_ready = 1'b0; PREADY = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = '0;
        cmd_addr = 32'h300; tick();
        cmd_addr = 32'h304; tick();
        cmd_addr = 32'h308; tick();
        cmd_addr = 32'h30C; tick();
        cmd_valid = 1'b0;
        checkOutput("rst.in_access", 32'(PENABLE), 1);
        checkOutput("rst.paddr",     PADDR, 32'h300);
        #2;
        nRST = 1'b0;
        #1;
        checkAllZero("rst.async");
        @(negedge CLK);
        nRST = 1'b1;
        PREADY = 1'b1;
        activity = 0;
        repeat (20) begin
            tick();
            if (PSEL || PENABLE || rsp_valid || busy || !cmd_ready) activity++;
        end
        checkOutput("rst.quiet", activity, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
